// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok;

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (pop_ok) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: nothing is presented while the count is zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // The credit scheme upstream must never let a push meet a full buffer.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_i && !flush_i) |-> (cnt_q != CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues imem reads under a credit limit, buffers
// returned words and hands them to decode; redirects flush and drop stale fetches.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_valid_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [PC_W-1:0]    inst_pc_o,
    output logic [PC_W-1:0]    pc_plus4_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            run_q;

    logic [CW-1:0]   count;
    logic            empty;
    logic [CW:0]     credit_sum;
    logic            issue;
    logic            rsp_ok;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] redirect_target;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign redirect_target = redirect_pc_i & ~PC_W'(3);
    assign credit_sum      = {1'b0, count} + {1'b0, outstanding_q};

    // run_q keeps imem_req low during reset and until the cycle after release.
    assign imem_req_o  = run_q && !redirect_valid_i && (credit_sum < (CW + 1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign issue       = imem_req_o && imem_gnt_i;
    assign rsp_ok      = imem_rvalid_i && (outstanding_q != '0);

    assign inst_valid_o  = !empty && !redirect_valid_i;
    assign pop           = inst_valid_o && inst_ready_i;
    assign instruction_o = head.instr;
    assign inst_pc_o     = head.pc;
    assign pc_plus4_o    = head.pc + PC_INC;

    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        push          = 1'b0;
        if (redirect_valid_i) begin
            fetch_pc_d    = redirect_target;
            resp_pc_d     = redirect_target;
            outstanding_d = outstanding_q - CW'(rsp_ok);
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d    = outstanding_q - CW'(rsp_ok);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
            outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_ok);
            if (rsp_ok) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + PC_INC;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            run_q         <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_valid_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .count_o (count)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: latency-configurable imem model plus a
// scoreboard of expected PCs popped on each decode handshake.
module tb_fetch_stage;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int n_issued;
    int first_pop_cyc;
    int last_pop_cyc;
    bit pop_seen = 1'b0;
    logic [31:0] exp_q [$];

    logic [2:0]  sv;
    logic [31:0] sa [3];

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (imem_gnt),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .instruction_o    (instruction),
        .inst_pc_o        (inst_pc),
        .pc_plus4_o       (pc_plus4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: reset together with the DUT, in-order, fixed latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv       <= '0;
            n_issued <= 0;
        end else begin
            sv[0] <= imem_req && imem_gnt;
            sa[0] <= imem_addr;
            sv[1] <= sv[0];
            sa[1] <= sa[0];
            sv[2] <= sv[1];
            sa[2] <= sa[1];
            if (imem_req && imem_gnt) n_issued <= n_issued + 1;
        end
    end

    assign imem_rvalid = sv[lat-1];
    assign imem_rdata  = sa[lat-1] ^ XOR_KEY;

    // Scoreboard: every decode handshake is compared while expectations remain.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready && exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check_eq("inst_pc", inst_pc, e);
            check_eq("instruction", instruction, e ^ XOR_KEY);
            check_eq("pc_plus4", pc_plus4, e + 32'd4);
            if (!pop_seen) first_pop_cyc = cyc;
            pop_seen     = 1'b1;
            last_pop_cyc = cyc;
        end
    end

    task automatic apply_reset(input int latency);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        lat = latency;
        exp_q.delete();
        pop_seen = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'h0);
        check_eq("rst_imem_req", 32'(imem_req), 32'h0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic wait_issued(input int n);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (n_issued >= n) break;
        end
        check_eq("issue_reached", 32'(n_issued), 32'(n));
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // 1: streaming after reset, one instruction per cycle
        inst_ready = 1'b1;
        apply_reset(1);
        push_seq(32'h0, 4);
        wait_drain("t1_drain");
        check_eq("t1_one_per_cycle", 32'(last_pop_cyc - first_pop_cyc), 32'd3);

        // 2: credit limit with decode stalled
        inst_ready = 1'b0;
        apply_reset(1);
        repeat (12) @(negedge clk);
        check_eq("t2_issues", 32'(n_issued), 32'd4);
        check_eq("t2_req_low", 32'(imem_req), 32'h0);
        push_seq(32'h0, 5);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        wait_drain("t2_drain");

        // 3: redirect with two fetches in flight on a 3-cycle memory
        inst_ready = 1'b0;
        apply_reset(3);
        wait_issued(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check_eq("t3_req_redirect", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        push_seq(32'h100, 2);
        @(negedge clk);
        check_eq("t3_new_addr", imem_addr, 32'h0000_0100);
        wait_drain("t3_drain");

        // 4: misaligned redirect near the top of the address space wraps
        inst_ready = 1'b1;
        apply_reset(1);
        repeat (6) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        exp_q.push_back(32'hFFFF_FFFC);
        push_seq(32'h0, 2);
        @(negedge clk);
        check_eq("t4_valid_redirect", 32'(inst_valid), 32'h0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_drain("t4_drain");

        // 5: grant withheld for three cycles
        inst_ready = 1'b1;
        apply_reset(1);
        push_seq(32'h0, 5);
        wait_issued(2);
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_addr_hold", imem_addr, 32'h8);
            check_eq("t5_req_hold", 32'(imem_req), 32'h1);
        end
        @(posedge clk);
        #1;
        imem_gnt = 1'b1;
        wait_drain("t5_drain");

        // 6: asynchronous reset with words buffered
        inst_ready = 1'b0;
        apply_reset(1);
        wait_issued(2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("t6_buffered", 32'(inst_valid), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_clear", 32'(inst_valid), 32'h0);
        apply_reset(1);
        push_seq(32'h0, 2);
        inst_ready = 1'b1;
        wait_drain("t6_drain");

        // 7: redirect flushes a full buffer
        inst_ready = 1'b0;
        apply_reset(1);
        repeat (10) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready = 1'b1;
        push_seq(32'h200, 2);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t7_flushed", 32'(inst_valid), 32'h0);
        wait_drain("t7_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
